// File: rtl/usb_tx_controller.sv
// usb_tx_controller: sequences one outgoing USB packet for the NRZI encoder.
// It generates the bit strobe and sends SYNC and then the payload bytes LSB first.
// It inserts a stuffed zero after six consecutive ones.
// It ends the packet with SE0, SE0 and a J bit.
module usb_tx_controller #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ack,
    output logic       d_orig,
    output logic       flag_8,
    output logic       pause,
    output logic       eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP, EJ, DONE} state_t;

    state_t          state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      bit_idx, bit_next;     // bit within SYNC/byte, or EOP bit number
    logic [2:0]      ones, ones_next;       // consecutive ones strobed so far
    logic [2:0]      ones_inc;
    logic            last_d, last_d_next;   // last raw bit sent, replayed as J
    logic [7:0]      shreg, shreg_next;
    logic            cur_last, cur_last_next;
    logic            byte_end, byte_end_next; // stuff bit sits on a byte boundary
    logic            d_next, ack_next, err_next;
    logic            do_boundary;

    // Bit timer: free-runs only while busy, so the first strobe is a full bit after start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt    <= '0;
            flag_8 <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            cnt    <= (!tx_busy || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            flag_8 <= tx_busy && (cnt == CNT_MAX);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state, datapath next values and the state-decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and
        // no latch is inferred.
        state_next    = state;
        bit_next      = bit_idx;
        ones_next     = ones;
        last_d_next   = last_d;
        shreg_next    = shreg;
        cur_last_next = cur_last;
        byte_end_next = byte_end;
        d_next        = d_orig;
        ack_next      = 1'b0;
        err_next      = 1'b0;
        do_boundary   = 1'b0;
        ones_inc      = d_orig ? ones + 3'd1 : 3'd0;
        pause         = (state == IDLE) || (state == DONE);
        eop           = (state == EOP);
        tx_busy       = (state != IDLE) && (state != DONE);
        tx_done       = (state == DONE);

        case (state)
            IDLE: if (tx_start) begin
                state_next    = SYNC;
                d_next        = 1'b0;
                bit_next      = 3'd0;
                ones_next     = 3'd0;
                last_d_next   = 1'b1;
                cur_last_next = 1'b0;
                byte_end_next = 1'b0;
            end
            SYNC: if (flag_8) begin
                last_d_next = d_orig;
                ones_next   = ones_inc;
                if (bit_idx == 3'd7) begin
                    do_boundary = 1'b1;
                end else begin
                    bit_next = bit_idx + 3'd1;
                    d_next   = (bit_idx == 3'd6);
                end
            end
            DATA: if (flag_8) begin
                last_d_next = d_orig;
                ones_next   = ones_inc;
                if (ones_inc == 3'd6) begin
                    state_next    = STUFF;
                    d_next        = 1'b0;
                    byte_end_next = (bit_idx == 3'd7);
                    bit_next      = bit_idx + 3'd1;
                end else if (bit_idx == 3'd7) begin
                    do_boundary = 1'b1;
                end else begin
                    bit_next = bit_idx + 3'd1;
                    d_next   = shreg[bit_idx + 3'd1];
                end
            end
            STUFF: if (flag_8) begin
                last_d_next = d_orig;
                ones_next   = 3'd0;
                if (byte_end) begin
                    do_boundary = 1'b1;
                end else begin
                    state_next = DATA;
                    d_next     = shreg[bit_idx];
                end
            end
            EOP: if (flag_8) begin
                if (bit_idx == 3'd0) begin
                    bit_next = 3'd1;
                end else begin
                    state_next = EJ;
                    d_next     = last_d;
                end
            end
            EJ: if (flag_8) begin
                state_next = DONE;
                d_next     = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Byte boundary: finish, load the next byte, or report an underrun.
        if (do_boundary) begin
            bit_next      = 3'd0;
            byte_end_next = 1'b0;
            if (cur_last) begin
                state_next = EOP;
            end else if (tx_data_valid) begin
                state_next    = DATA;
                shreg_next    = tx_data;
                cur_last_next = tx_last;
                d_next        = tx_data[0];
                ack_next      = 1'b1;
            end else begin
                state_next = EOP;
                err_next   = 1'b1;
            end
        end
    end

    // Datapath registers and registered pulse outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_orig      <= 1'b1;
            bit_idx     <= 3'd0;
            ones        <= 3'd0;
            last_d      <= 1'b1;
            shreg       <= 8'h00;
            cur_last    <= 1'b0;
            byte_end    <= 1'b0;
            tx_data_ack <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            d_orig      <= d_next;
            bit_idx     <= bit_next;
            ones        <= ones_next;
            last_d      <= last_d_next;
            shreg       <= shreg_next;
            cur_last    <= cur_last_next;
            byte_end    <= byte_end_next;
            tx_data_ack <= ack_next;
            tx_error    <= err_next;
        end
    end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Directed testbench for usb_tx_controller (CLKS_PER_BIT=8 and CLKS_PER_BIT=4 instances).
module tb_usb_tx_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0, tx_start4 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0, tx_last = 1'b0;

    logic tx_data_ack, d_orig, flag_8, pause, eop, tx_busy, tx_done, tx_error;
    logic ack4, d_orig4, flag4, pause4, eop4, busy4, done4, err4;

    usb_tx_controller #(.CLKS_PER_BIT(8)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_last(tx_last), .tx_data_ack(tx_data_ack),
        .d_orig(d_orig), .flag_8(flag_8), .pause(pause), .eop(eop),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error));

    usb_tx_controller #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start4), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_last(tx_last), .tx_data_ack(ack4),
        .d_orig(d_orig4), .flag_8(flag4), .pause(pause4), .eop(eop4),
        .tx_busy(busy4), .tx_done(done4), .tx_error(err4));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;

    // Cycle counter, advanced on the active edge so negedge samplers see it stable.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the 8-clock instance: strobed bits, pulses, ack times.
    int flags = 0, eops = 0, nbits = 0, acks = 0, errs = 0, dones = 0;
    int prev_ack = 0, last_ack = 0;
    logic [63:0] bits_v = '0;
    always @(negedge clk) begin
        if (flag_8) begin
            flags++;
            if (eop) eops++;
            else begin bits_v = {bits_v[62:0], d_orig}; nbits++; end
        end
        if (tx_data_ack) begin acks++; prev_ack = last_ack; last_ack = cyc; end
        if (tx_error) errs++;
        if (tx_done) dones++;
    end

    // Monitor for the 4-clock instance, including strobe period.
    int flags4 = 0, eops4 = 0, nbits4 = 0, dones4 = 0, bad4 = 0, last4 = 0;
    logic [63:0] bits4_v = '0;
    always @(negedge clk) begin
        if (flag4) begin
            if (flags4 > 0 && cyc - last4 != 4) bad4++;
            last4 = cyc;
            flags4++;
            if (eop4) eops4++;
            else begin bits4_v = {bits4_v[62:0], d_orig4}; nbits4++; end
        end
        if (done4) dones4++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  s_flags, s_eops, s_nbits, s_acks, s_errs, s_dones;
    int  start_cyc, first_off, done_off;
    bit  got_done;

    // Runs one packet of n (1 or 2) bytes; optionally drops valid after the first ack,
    // and optionally pulses tx_start in the DONE cycle.
    task automatic run_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input bit underrun, input bit start_in_done);
        bit first_seen;
        @(negedge clk); #1;
        s_flags = flags; s_eops = eops; s_nbits = nbits;
        s_acks = acks; s_errs = errs; s_dones = dones;
        tx_data = b0; tx_last = (n == 1); tx_data_valid = 1'b1;
        tx_start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_after_start", tx_busy, 1);
        got_done = 0; first_seen = 0; first_off = 0; done_off = 0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(negedge clk);
            if (flag_8 && !first_seen) begin first_seen = 1; first_off = cyc - start_cyc; end
            if (tx_data_ack && n == 2) begin
                if (underrun) tx_data_valid = 1'b0;
                else begin tx_data = b1; tx_last = 1'b1; end
            end
            if (tx_done) begin
                got_done = 1; done_off = cyc - start_cyc;
                if (start_in_done) tx_start = 1'b1;
            end
        end
        @(negedge clk);
        tx_start = 1'b0;
        #1;
        if (start_in_done) check("start_in_done_ignored", tx_busy, 0);
    endtask

    task automatic check_pkt(input string tag, input int e_flags, input int e_nb,
                             input logic [63:0] e_bits, input int e_acks, input int e_errs);
        int nb;
        nb = nbits - s_nbits;
        check({tag, ".done_seen"}, 64'(got_done), 1);
        check({tag, ".flags"}, 64'(flags - s_flags), 64'(e_flags));
        check({tag, ".eop_strobes"}, 64'(eops - s_eops), 2);
        check({tag, ".nbits"}, 64'(nb), 64'(e_nb));
        check({tag, ".bits"}, bits_v & ((64'd1 << nb) - 64'd1), e_bits);
        check({tag, ".acks"}, 64'(acks - s_acks), 64'(e_acks));
        check({tag, ".errors"}, 64'(errs - s_errs), 64'(e_errs));
        check({tag, ".dones"}, 64'(dones - s_dones), 1);
        check({tag, ".first_flag"}, 64'(first_off), 9);
        check({tag, ".done_time"}, 64'(done_off), 64'(e_flags * 8 + 2));
    endtask

    int  nf, first4, done4_off, st4;
    bit  hit, got4, f4;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("reset.outs8", {d_orig, pause, flag_8, eop, tx_busy, tx_data_ack, tx_done, tx_error}, 8'b1100_0000);
        check("reset.outs4", {d_orig4, pause4, flag4, eop4, busy4, ack4, done4, err4}, 8'b1100_0000);
        n_rst = 1'b1;

        // 1: single 0x00 byte
        run_pkt(1, 8'h00, 8'h00, 0, 0);
        check_pkt("t1", 19, 17, 64'(17'b00000001_00000000_0), 1, 0);

        // 2: single 0xFF byte, one stuff; tx_start in DONE is ignored
        run_pkt(1, 8'hFF, 8'h00, 0, 1);
        check_pkt("t2", 20, 18, 64'(18'b00000001_11111_0_111_1), 1, 0);

        // 3: 0x3F,0xC0 - stuff inside the first byte
        run_pkt(2, 8'h3F, 8'hC0, 0, 0);
        check_pkt("t3", 28, 26, 64'(26'b00000001_11111_0_100_00000011_1), 2, 0);
        check("t3.ack_gap", 64'(last_ack - prev_ack), 72);

        // 3b: 0xFC,0x03 - stuff exactly on the byte boundary
        run_pkt(2, 8'hFC, 8'h03, 0, 0);
        check_pkt("t3b", 28, 26, 64'(26'b00000001_00111111_0_11000000_0), 2, 0);
        check("t3b.ack_gap", 64'(last_ack - prev_ack), 72);

        // 4: underrun at the first boundary
        run_pkt(2, 8'h55, 8'h00, 1, 0);
        check_pkt("t4", 19, 17, 64'(17'b00000001_10101010_0), 1, 1);

        // 5: reset during DATA bit 3, then a normal packet
        @(negedge clk);
        tx_data = 8'h00; tx_last = 1'b1; tx_data_valid = 1'b1; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; nf = 0; hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (flag_8) nf++;
            if (nf == 12) hit = 1;
        end
        check("t5.reached_bit3", 64'(hit), 1);
        #1;
        s_dones = dones; s_errs = errs;
        n_rst = 1'b0;
        #1;
        check("t5.reset_outs", {d_orig, pause, flag_8, eop, tx_busy, tx_data_ack, tx_done, tx_error}, 8'b1100_0000);
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("t5.no_done_pulse", 64'(dones - s_dones), 0);
        check("t5.no_error_pulse", 64'(errs - s_errs), 0);
        run_pkt(1, 8'h00, 8'h00, 0, 0);
        check_pkt("t5r", 19, 17, 64'(17'b00000001_00000000_0), 1, 0);

        // 6: CLKS_PER_BIT=4, with tx_start pulsed mid-packet
        @(negedge clk); #1;
        tx_data = 8'h00; tx_last = 1'b1; tx_data_valid = 1'b1;
        tx_start4 = 1'b1; st4 = cyc;
        @(negedge clk);
        tx_start4 = 1'b0; got4 = 0; f4 = 0; first4 = 0; done4_off = 0;
        for (int i = 0; i < 400 && !got4; i++) begin
            @(negedge clk);
            tx_start4 = (i == 30);
            if (flag4 && !f4) begin f4 = 1; first4 = cyc - st4; end
            if (done4) begin got4 = 1; done4_off = cyc - st4; end
        end
        tx_start4 = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("t6.done_seen", 64'(got4), 1);
        check("t6.flags", 64'(flags4), 19);
        check("t6.period_errors", 64'(bad4), 0);
        check("t6.eop_strobes", 64'(eops4), 2);
        check("t6.nbits", 64'(nbits4), 17);
        check("t6.bits", bits4_v & ((64'd1 << 17) - 64'd1), 64'(17'b00000001_00000000_0));
        check("t6.dones", 64'(dones4), 1);
        check("t6.first_flag", 64'(first4), 5);
        check("t6.done_time", 64'(done4_off), 78);
        check("t6.idle_after", 64'(busy4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
